// File: rtl/is_uart_tx_arb.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte
// sources. It accepts one byte per grant and pulses the transmitter's start.
// It then follows the transmitter's busy flag and waits an inter-frame gap,
// counted in baud ticks, before it arbitrates again.
module is_uart_tx_arb #(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic                    baud_tick_i,
  input  logic                    tx_busy_i,
  output logic                    tx_start_o,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    arb_busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]  grant_q, grant_d;

  logic [PTR_W-1:0]  winner;
  logic              found;
  logic [N_REQ-1:0]  ready;
  logic              accept;
  int                scanSum;
  logic [PTR_W-1:0]  scanIdx;
  logic [DATA_W-1:0] reqBytes [N_REQ];

  // Split the flat data bus into one byte per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign reqBytes[g] = req_data_i[g*DATA_W +: DATA_W];
  end

  // Pick the first valid requester after the pointer, wrapping around.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    scanSum = 0;
    scanIdx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scanSum = int'(ptr_q) + i;
      if (scanSum >= N_REQ) scanSum = scanSum - N_REQ;
      scanIdx = PTR_W'(scanSum);
      if (!found && req_valid_i[scanIdx]) begin
        found  = 1'b1;
        winner = scanIdx;
      end
    end
  end

  // Offer ready only to the winner, and only while idle with the transmitter free.
  always_comb begin
    ready = '0;
    if (state_q == IDLE && !tx_busy_i && found) ready[winner] = 1'b1;
  end

  assign accept      = |(ready & req_valid_i);
  assign req_ready_o = ready;
  assign tx_start_o  = (state_q == START);
  assign tx_data_o   = data_q;
  assign grant_o     = grant_q;
  assign arb_busy_o  = (state_q != IDLE);

  // Next state: accept, start pulse, track busy, then count the gap ticks.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = reqBytes[winner];
          grant_d = ready;
          ptr_d   = winner;
          state_d = START;
        end
      end
      START: begin
        state_d = tx_busy_i ? WAIT_DONE : WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy_i) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          if (GAP_TICKS > 0) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      GAP: begin
        if (baud_tick_i) begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset puts req 0 first in line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(N_REQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

endmodule
